// File: rtl/lc4_div_seq.sv
// lc4_div_seq: multi-cycle 16-bit unsigned divider (DIV/MOD) for the LC4 ALU.
// Restoring division with one quotient bit per cycle. A single cla16 is the
// only adder, and it forms rem - divisor as rem + ~divisor + 1.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous reset, active low
//   i_start      request, sampled only in IDLE
//   i_dividend   dividend, captured on an accepted start
//   i_divisor    divisor, captured on an accepted start
//   i_ready      consumer accepts the result when o_valid & i_ready
//   o_busy       high in CALC and DONE, so start is not accepted
//   o_valid      result valid, high only in DONE
//   o_quotient   quotient, 0 outside DONE
//   o_remainder  remainder, 0 outside DONE
//
// Build option
//   LC4_DIV_ZERO_FAST_EN: a zero divisor on an accepted start goes straight
//   from IDLE to DONE.

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    // Carry-in for each of four positions, given generate/propagate and a carry-in.
    function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p,
                                            input logic ci);
        logic [3:0] c;
        c[0] = ci;
        for (int unsigned i = 1; i < 4; i++)
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        return c;
    endfunction

    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, gc;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int unsigned k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
                    (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                    (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc = carries4(gg, gp, cin);
        c  = '0;
        for (int unsigned k = 0; k < 4; k++)
            c[4*k +: 4] = carries4(g[4*k +: 4], p[4*k +: 4], gc[k]);
        sum = p ^ c;
    end
endmodule

module lc4_div_seq #(
    parameter logic [15:0] DIV0_Q = 16'h0000,
    parameter logic [15:0] DIV0_R = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_valid,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] q, rem, d;
    logic [3:0]  count;
    logic [15:0] sh, diff, d_inv;
    logic        top, cout, ge;

    assign sh    = {rem[14:0], q[15]};
    assign top   = rem[15];
    assign d_inv = ~d;

    cla16 u_add (.a(sh), .b(d_inv), .cin(1'b1), .sum(diff));

    // Carry-out of the 16-bit subtract is rebuilt from the MSB slice.
    // A set carry means no borrow, so sh >= d. A set top bit means the
    // shifted 17-bit remainder already exceeds any 16-bit divisor.
    assign cout = (sh[15] & d_inv[15]) | ((sh[15] ^ d_inv[15]) & ~diff[15]);
    assign ge   = top | cout;

    assign o_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_start) begin
`ifdef LC4_DIV_ZERO_FAST_EN
                if (i_divisor == '0) state_next = DONE;
                else                 state_next = CALC;
`else
                state_next = CALC;
`endif
            end
            CALC: if (count == 4'd15) state_next = DONE;
            DONE: if (o_valid && i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are registered one cycle after DONE is entered. The output
    // registers are cleared on the accepting handshake, so they read 0
    // everywhere outside DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q           <= '0;
            rem         <= '0;
            d           <= '0;
            count       <= '0;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    q     <= i_dividend;
                    rem   <= '0;
                    d     <= i_divisor;
                    count <= '0;
                end
                CALC: begin
                    rem   <= ge ? diff : sh;
                    q     <= {q[14:0], ge};
                    count <= count + 4'd1;
                end
                DONE: begin
                    if (!o_valid) begin
                        o_valid     <= 1'b1;
                        o_quotient  <= (d == '0) ? DIV0_Q : q;
                        o_remainder <= (d == '0) ? DIV0_R : rem;
                    end else if (i_ready) begin
                        o_valid     <= 1'b0;
                        o_quotient  <= '0;
                        o_remainder <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lc4_div_seq.sv
// tb_lc4_div_seq: self-checking bench for lc4_div_seq. Expected results are
// pushed to a scoreboard queue when a start is driven. They are popped and
// compared when the DUT presents o_valid.

module tb_lc4_div_seq;
    localparam logic [15:0] TB_DIV0_Q = 16'h0000;
    localparam logic [15:0] TB_DIV0_R = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic        i_ready;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_quotient;
    logic [15:0] o_remainder;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    lc4_div_seq #(.DIV0_Q(TB_DIV0_Q), .DIV0_R(TB_DIV0_R)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_dividend(i_dividend),
        .i_divisor(i_divisor), .i_ready(i_ready), .o_busy(o_busy),
        .o_valid(o_valid), .o_quotient(o_quotient), .o_remainder(o_remainder)
    );

    function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'h0000) return {TB_DIV0_Q, TB_DIV0_R};
        return {a / b, a % b};
    endfunction

    function automatic int exp_latency(input logic [15:0] b);
`ifdef LC4_DIV_ZERO_FAST_EN
        if (b == 16'h0000) return 1;
`endif
        return 17;
    endfunction

    // Drive one start with i_ready held high. Checks latency, the result
    // against the scoreboard, and that o_valid lasts a single cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [31:0] exp;
        int          lat;
        @(negedge clk);
        i_ready    = 1'b1;
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        sb.push_back(golden(a, b));
        @(negedge clk);
        i_start = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== exp_latency(b)) begin
            n_err++;
            $display("FAIL %s latency %0d/%0d: got %0d want %0d", tag, a, b, lat, exp_latency(b));
        end
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_in_done: got %b want 1", tag, o_busy);
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard_empty: got 0 entries want 1", tag);
        end else begin
            exp = sb.pop_front();
            n_vec++;
            if (o_quotient !== exp[31:16]) begin
                n_err++;
                $display("FAIL %s quotient %0d/%0d: got %h want %h", tag, a, b, o_quotient, exp[31:16]);
            end
            n_vec++;
            if (o_remainder !== exp[15:0]) begin
                n_err++;
                $display("FAIL %s remainder %0d/%0d: got %h want %h", tag, a, b, o_remainder, exp[15:0]);
            end
        end
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_accept: got valid=%b busy=%b want 0 0", tag, o_valid, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_start = 1'b0; i_dividend = '0; i_divisor = '0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({o_busy, o_valid, o_quotient, o_remainder} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b valid=%b q=%h r=%h want all 0",
                     o_busy, o_valid, o_quotient, o_remainder);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_basic();
        run_op(16'd100, 16'd7, "basic");
    endtask

    task automatic test_boundaries();
        run_op(16'hFFFF, 16'h0001, "max_by_one");
        run_op(16'h8000, 16'hFFFF, "msb_by_max");
        run_op(16'hFFFF, 16'hFFFF, "max_by_max");
        run_op(16'h0000, 16'h0005, "zero_dividend");
    endtask

    task automatic test_div0();
        run_op(16'd1234, 16'd0, "div0");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int          lat;
        @(negedge clk);
        i_ready = 1'b0;
        i_start = 1'b1; i_dividend = 16'd1000; i_divisor = 16'd33;
        sb.push_back(golden(16'd1000, 16'd33));
        @(negedge clk);
        i_start = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 17) begin
            n_err++;
            $display("FAIL bp_latency: got %0d want 17", lat);
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                i_start = 1'b1; i_dividend = 16'd77; i_divisor = 16'd3;
            end else begin
                i_start = 1'b0;
            end
            n_vec++;
            if (o_valid !== 1'b1 || o_quotient !== exp[31:16] || o_remainder !== exp[15:0]) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got v=%b q=%h r=%h want v=1 q=%h r=%h",
                         i, o_valid, o_quotient, o_remainder, exp[31:16], exp[15:0]);
            end
            @(negedge clk);
        end
        // Raise start in the same cycle as the accepting ready. It must not be taken.
        i_ready = 1'b1;
        i_start = 1'b1; i_dividend = 16'd77; i_divisor = 16'd3;
        @(negedge clk);
        i_start = 1'b0;
        n_vec++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_quotient !== 16'h0) begin
            n_err++;
            $display("FAIL bp_release: got v=%b busy=%b q=%h want 0 0 0", o_valid, o_busy, o_quotient);
        end
        @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_same_cycle_start_ignored: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        i_ready = 1'b1;
        i_start = 1'b1; i_dividend = 16'd5000; i_divisor = 16'd3;
        @(negedge clk);
        i_start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({o_busy, o_valid, o_quotient, o_remainder} !== 34'h0) begin
            n_err++;
            $display("FAIL midop_reset: got busy=%b valid=%b q=%h r=%h want all 0",
                     o_busy, o_valid, o_quotient, o_remainder);
        end
        rst = 1'b1;
        run_op(16'd50, 16'd5, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(0, 15));
                1: b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            run_op(a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div0();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
